// File: rtl/cpu_seq_pkg.sv
// Shared types and defaults for the CPU instruction sequencer (cpu_seq_ctl).
// The optional breakpoint logic in the top is enabled by CPU_SEQ_BREAKPOINT_EN.
package cpu_seq_pkg;

    localparam int CPU_SEQ_ADDR_W  = 16;
    localparam int CPU_SEQ_DATA_W  = 16;
    localparam int CPU_SEQ_ROM_LAT = 2;
    localparam int CPU_SEQ_RAM_LAT = 2;
    localparam int CTR_W           = 3;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        FWAIT,
        EXEC,
        RESP,
        MEM,
        MWAIT,
        NEXT,
        HALT
    } seq_state_t;

    // Wait counter preload: a latency of N cycles counts N-1 down to 0.
    function automatic logic [CTR_W-1:0] lat_load(input int lat);
        return CTR_W'(lat - 1);
    endfunction

endpackage

// File: rtl/cpu_seq_waitctr.sv
// Load/decrement wait counter with zero flag, shared by the ROM and RAM wait states.
module cpu_seq_waitctr
    import cpu_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CTR_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/cpu_seq_ctl.sv
// CPU instruction sequencer: owns the PC and runs fetch -> execute -> RAM port A -> PC update.
// Define CPU_SEQ_BREAKPOINT_EN to add the bp_addr/bp_en/bp_hit breakpoint feature.
module cpu_seq_ctl
    import cpu_seq_pkg::*;
#(
    parameter int                ADDR_W   = CPU_SEQ_ADDR_W,
    parameter int                DATA_W   = CPU_SEQ_DATA_W,
    parameter int                ROM_LAT  = CPU_SEQ_ROM_LAT,
    parameter int                RAM_LAT  = CPU_SEQ_RAM_LAT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] ir,
    output logic              alu_en,
    input  logic              alu_mem_req,
    input  logic              alu_mem_we,
    input  logic [ADDR_W-1:0] alu_mem_addr,
    input  logic [DATA_W-1:0] alu_mem_wdata,
    input  logic              alu_branch,
    input  logic [ADDR_W-1:0] alu_target,
    input  logic              alu_halt,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
`ifdef CPU_SEQ_BREAKPOINT_EN
   ,input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_en,
    output logic              bp_hit
`endif
);

    seq_state_t        state_reg;
    logic              step_pend_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;

    logic              ctr_load;
    logic [CTR_W-1:0]  ctr_load_val;
    logic              ctr_dec;
    logic              ctr_zero;
    logic [ADDR_W-1:0] pc_next;
    logic              go;

    cpu_seq_waitctr u_waitctr (
        .clock    (clock),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

    assign ctr_load     = (state_reg == FETCH) || ((state_reg == MEM) && !mem_we_reg);
    assign ctr_load_val = (state_reg == FETCH) ? lat_load(ROM_LAT) : lat_load(RAM_LAT);
    assign ctr_dec      = (state_reg == FWAIT) || (state_reg == MWAIT);
    assign pc_next      = alu_branch ? alu_target : pc + ADDR_W'(1);

`ifdef CPU_SEQ_BREAKPOINT_EN
    logic run_q_reg;
    logic bp_skip_reg;
    logic run_rise;
    logic trip_idle;
    logic trip_next;

    // After a breakpoint only a fresh run edge or a step resumes the sequencer.
    assign run_rise  = run && !run_q_reg;
    assign go        = bp_hit ? (run_rise || step) : (run || step || step_pend_reg);
    assign trip_idle = bp_en && (pc == bp_addr) && !bp_skip_reg;
    assign trip_next = bp_en && (pc_next == bp_addr) && !bp_skip_reg;
`else
    assign go = run || step || step_pend_reg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            pc            <= RESET_PC;
            step_pend_reg <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            rom_address   <= '0;
            ram_address   <= '0;
            ir            <= '0;
            ram_data      <= '0;
            mem_rdata     <= '0;
            alu_en        <= 1'b0;
            ram_wren      <= 1'b0;
            mem_rvalid    <= 1'b0;
            halted        <= 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
            run_q_reg     <= 1'b0;
            bp_skip_reg   <= 1'b0;
            bp_hit        <= 1'b0;
`endif
        end else begin
            alu_en     <= 1'b0;
            ram_wren   <= 1'b0;
            mem_rvalid <= 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
            run_q_reg <= run;
            if (bp_hit && (run_rise || step)) begin
                bp_hit <= 1'b0;
            end
`endif
            if (step && !run && (state_reg != HALT)) begin
                step_pend_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (go) begin
`ifdef CPU_SEQ_BREAKPOINT_EN
                        if (trip_idle) begin
                            bp_hit        <= 1'b1;
                            bp_skip_reg   <= 1'b1;
                            step_pend_reg <= 1'b0;
                        end else begin
                            state_reg <= FETCH;
                        end
`else
                        state_reg <= FETCH;
`endif
                    end
                end
                FETCH: begin
                    rom_address <= pc;
                    state_reg   <= FWAIT;
`ifdef CPU_SEQ_BREAKPOINT_EN
                    bp_skip_reg <= 1'b0;
`endif
                end
                FWAIT: begin
                    if (ctr_zero) begin
                        ir        <= rom_q;
                        alu_en    <= 1'b1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    state_reg <= RESP;
                end
                RESP: begin
                    if (alu_halt) begin
                        halted    <= 1'b1;
                        state_reg <= HALT;
                    end else if (alu_mem_req) begin
                        mem_we_reg   <= alu_mem_we;
                        mem_addr_reg <= alu_mem_addr;
                        // Writes are presented during MEM so the strobe never leaves that state.
                        if (alu_mem_we) begin
                            ram_address <= alu_mem_addr;
                            ram_data    <= alu_mem_wdata;
                            ram_wren    <= 1'b1;
                        end
                        state_reg <= MEM;
                    end else begin
                        step_pend_reg <= 1'b0;
                        state_reg     <= NEXT;
                    end
                end
                MEM: begin
                    if (mem_we_reg) begin
                        step_pend_reg <= 1'b0;
                        state_reg     <= NEXT;
                    end else begin
                        ram_address <= mem_addr_reg;
                        state_reg   <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (ctr_zero) begin
                        mem_rdata     <= ram_q;
                        mem_rvalid    <= 1'b1;
                        step_pend_reg <= 1'b0;
                        state_reg     <= NEXT;
                    end
                end
                NEXT: begin
                    pc <= pc_next;
                    if (run) begin
`ifdef CPU_SEQ_BREAKPOINT_EN
                        if (trip_next) begin
                            bp_hit      <= 1'b1;
                            bp_skip_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            state_reg <= FETCH;
                        end
`else
                        state_reg <= FETCH;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                HALT: begin
                    state_reg <= HALT;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
